// File: rtl/regfile_cmd_ctrl.sv
// Byte-command front end for a register file: 0xAA addr data writes, 0xBB addr reads and returns the byte.
// Write 1 cycle after the data byte; read strobe 1 cycle after valid data; TX_BUSY holds the response.
module regfile_cmd_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic             RF_WrEn,
  output logic             RF_RdEn,
  output logic [ADDR-1:0]  RF_Address,
  output logic [WIDTH-1:0] RF_WrData,
  input  logic [WIDTH-1:0] RF_RdData,
  input  logic             RF_RdData_VLD,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             TX_BUSY,
  output logic             CTRL_BUSY,
  output logic             ERR
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    TMAX   = CW'(TIMEOUT);
  localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT} state_t;

  state_t           state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] wrdata_q, wrdata_d;
  logic [WIDTH-1:0] txdat_q, txdat_d;
  logic [WIDTH-1:0] rdbyte_q, rdbyte_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wren_q, wren_d;
  logic             rden_q, rden_d;
  logic             txvld_q, txvld_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             addr_legal;
  logic [CW-1:0]    cnt_inc;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wrdata_d   = wrdata_q;
    txdat_d    = txdat_q;
    rdbyte_d   = rdbyte_q;
    cnt_d      = cnt_q;
    wren_d     = 1'b0;
    rden_d     = 1'b0;
    txvld_d    = 1'b0;
    err_d      = 1'b0;
    addr_legal = ((RX_P_DATA >> ADDR) == '0);
    cnt_inc    = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)      state_d = WR_ADDR;
          else if (RX_P_DATA == CMD_RD) state_d = RD_ADDR;
          else                          err_d   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_legal) begin
            addr_d  = RX_P_DATA[ADDR-1:0];
            state_d = WR_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_legal) begin
            addr_d  = RX_P_DATA[ADDR-1:0];
            rden_d  = 1'b1;
            cnt_d   = '0;
            state_d = RD_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RD_WAIT: begin
        // Valid is ignored while our own read strobe is still on the bus.
        err_d = RX_D_VLD;
        cnt_d = cnt_inc;
        if (!rden_q && RF_RdData_VLD) begin
          rdbyte_d = RF_RdData;
          if (!TX_BUSY) begin
            txdat_d = RF_RdData;
            txvld_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = TX_WAIT;
          end
        end else if (cnt_inc == TMAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TX_WAIT: begin
        err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          txdat_d = rdbyte_q;
          txvld_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wrdata_q <= '0;
      txdat_q  <= '0;
      rdbyte_q <= '0;
      cnt_q    <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      txvld_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      txdat_q  <= txdat_d;
      rdbyte_q <= rdbyte_d;
      cnt_q    <= cnt_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      txvld_q  <= txvld_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign RF_WrEn    = wren_q;
  assign RF_RdEn    = rden_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wrdata_q;
  assign TX_P_DATA  = txdat_q;
  assign TX_D_VLD   = txvld_q;
  assign CTRL_BUSY  = busy_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl: directed scenarios plus random command frames against a transaction-level model.
module tb_regfile_cmd_ctrl;
  localparam int WIDTH   = 8;
  localparam int ADDR    = 4;
  localparam int TIMEOUT = 15;

  logic             CLK, RST;
  logic [WIDTH-1:0] RX_P_DATA;
  logic             RX_D_VLD;
  logic             RF_WrEn, RF_RdEn;
  logic [ADDR-1:0]  RF_Address;
  logic [WIDTH-1:0] RF_WrData, RF_RdData, TX_P_DATA;
  logic             RF_RdData_VLD, TX_D_VLD, TX_BUSY, CTRL_BUSY, ERR;

  regfile_cmd_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .CTRL_BUSY(CTRL_BUSY), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] rf_init(input int i);
    case (i)
      2:       return 8'h81;
      3:       return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  // Register-file model: one-cycle read latency, optional silence for timeout tests.
  logic [7:0] rf_mem [16];
  logic       rf_mute;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= rf_init(i);
      RF_RdData_VLD <= 1'b0;
      RF_RdData     <= '0;
    end else begin
      if (RF_WrEn) rf_mem[RF_Address] <= RF_WrData;
      RF_RdData_VLD <= RF_RdEn && !rf_mute;
      if (RF_RdEn) RF_RdData <= rf_mem[RF_Address];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int err_cnt = 0, wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, both_cnt = 0, busy_viol = 0, busy_cnt = 0;
  int err_cyc = 0, wr_cyc = 0, rd_cyc = 0, tx_cyc = 0, vld_cyc = 0;
  logic [7:0] wr_addr = 0, wr_dat = 0, rd_addr = 0, tx_dat = 0;

  always @(negedge CLK) begin
    if (ERR) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
    if (RF_WrEn) begin wr_cnt <= wr_cnt + 1; wr_cyc <= cyc; wr_addr <= 8'(RF_Address); wr_dat <= RF_WrData; end
    if (RF_RdEn) begin rd_cnt <= rd_cnt + 1; rd_cyc <= cyc; rd_addr <= 8'(RF_Address); end
    if (RF_WrEn && RF_RdEn) both_cnt <= both_cnt + 1;
    if (TX_D_VLD) begin
      tx_cnt <= tx_cnt + 1; tx_cyc <= cyc; tx_dat <= TX_P_DATA;
      if (TX_BUSY) busy_viol <= busy_viol + 1;
    end
    if (RF_RdData_VLD) vld_cyc <= cyc;
    if (CTRL_BUSY) busy_cnt <= busy_cnt + 1;
  end

  int n_tests = 0, n_fail = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int acc_cyc = 0;
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge CLK);
    @(posedge CLK); #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    acc_cyc   = cyc;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (CTRL_BUSY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check_eq("idle_within_bound", 32'(CTRL_BUSY), 0);
    repeat (2) @(negedge CLK);
  endtask

  logic [7:0] ref_mem [16];
  int s_err, s_wr, s_rd, s_tx, s_busy, a_cyc, fall_cyc;

  task automatic snap();
    s_err = err_cnt; s_wr = wr_cnt; s_rd = rd_cnt; s_tx = tx_cnt; s_busy = busy_cnt;
  endtask

  initial begin
    logic [7:0] a, d, b;
    int kind, e_err, e_wr, e_rd, e_tx;

    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; TX_BUSY = 1'b0; rf_mute = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = rf_init(i);
    #3;
    check_eq("rst_wren",   32'(RF_WrEn), 0);
    check_eq("rst_rden",   32'(RF_RdEn), 0);
    check_eq("rst_addr",   32'(RF_Address), 0);
    check_eq("rst_wrdata", 32'(RF_WrData), 0);
    check_eq("rst_txdat",  32'(TX_P_DATA), 0);
    check_eq("rst_txvld",  32'(TX_D_VLD), 0);
    check_eq("rst_busy",   32'(CTRL_BUSY), 0);
    check_eq("rst_err",    32'(ERR), 0);
    #20;
    @(posedge CLK); #1 RST = 1'b1;
    repeat (2) @(posedge CLK);

    // Read of the reset value at address 2, TX free: bypass straight to the strobe.
    snap();
    send_byte(8'hBB, 0); send_byte(8'h02, 0); a_cyc = acc_cyc;
    wait_idle();
    check_eq("rd2_rden_cnt", rd_cnt - s_rd, 1);
    check_eq("rd2_addr",     32'(rd_addr), 2);
    check_eq("rd2_rden_lat", rd_cyc - a_cyc, 1);
    check_eq("rd2_tx_cnt",   tx_cnt - s_tx, 1);
    check_eq("rd2_tx_dat",   32'(tx_dat), 32'h81);
    check_eq("rd2_tx_lat",   tx_cyc - vld_cyc, 1);

    // Read with TX busy for 20 cycles, plus a stray byte while waiting.
    snap();
    TX_BUSY = 1'b1;
    send_byte(8'hBB, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 5);
    repeat (20) @(posedge CLK);
    #1;
    check_eq("busy_no_tx",    tx_cnt - s_tx, 0);
    check_eq("busy_stray_err", err_cnt - s_err, 1);
    check_eq("busy_ctrl_busy", 32'(CTRL_BUSY), 1);
    @(posedge CLK); #1 TX_BUSY = 1'b0; fall_cyc = cyc;
    wait_idle();
    check_eq("busy_tx_cnt", tx_cnt - s_tx, 1);
    check_eq("busy_tx_dat", 32'(tx_dat), 32'h20);
    check_eq("busy_tx_lat", tx_cyc - fall_cyc, 1);
    check_eq("busy_err_total", err_cnt - s_err, 1);

    // Write then read back.
    snap();
    send_byte(8'hAA, 0); send_byte(8'h05, 1); send_byte(8'h3C, 2); a_cyc = acc_cyc;
    wait_idle();
    ref_mem[5] = 8'h3C;
    check_eq("wr_cnt",  wr_cnt - s_wr, 1);
    check_eq("wr_addr", 32'(wr_addr), 5);
    check_eq("wr_dat",  32'(wr_dat), 32'h3C);
    check_eq("wr_lat",  wr_cyc - a_cyc, 1);
    send_byte(8'hBB, 0); send_byte(8'h05, 0);
    wait_idle();
    check_eq("wrrd_tx_dat", 32'(tx_dat), 32'h3C);
    check_eq("wrrd_rd_cnt", rd_cnt - s_rd, 1);

    // Bad command and bad address.
    snap();
    send_byte(8'h7E, 0);
    repeat (3) @(negedge CLK);
    check_eq("badcmd_err",  err_cnt - s_err, 1);
    check_eq("badcmd_busy", busy_cnt - s_busy, 0);
    send_byte(8'hAA, 0); send_byte(8'h12, 0);
    wait_idle();
    check_eq("badaddr_err", err_cnt - s_err, 2);
    check_eq("badaddr_wr",  wr_cnt - s_wr, 0);

    // Read timeout.
    snap();
    rf_mute = 1'b1;
    send_byte(8'hBB, 0); send_byte(8'h01, 0);
    wait_idle();
    rf_mute = 1'b0;
    check_eq("to_err",      err_cnt - s_err, 1);
    check_eq("to_err_time", err_cyc - rd_cyc, TIMEOUT);
    check_eq("to_no_tx",    tx_cnt - s_tx, 0);
    check_eq("to_idle",     32'(CTRL_BUSY), 0);

    // Stray byte in the last wait cycle coincides with the timeout: one pulse only.
    snap();
    rf_mute = 1'b1;
    send_byte(8'hBB, 0); send_byte(8'h01, 0);
    repeat (TIMEOUT - 1) @(posedge CLK);
    #1 RX_P_DATA = 8'h55; RX_D_VLD = 1'b1;
    @(posedge CLK); #1 RX_D_VLD = 1'b0;
    wait_idle();
    rf_mute = 1'b0;
    check_eq("coinc_err",      err_cnt - s_err, 1);
    check_eq("coinc_err_time", err_cyc - rd_cyc, TIMEOUT);

    // Reset mid-frame abandons the write; following bytes decode as commands.
    send_byte(8'hAA, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    #1 check_eq("midrst_busy", 32'(CTRL_BUSY), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = rf_init(i);
    snap();
    send_byte(8'h04, 0); send_byte(8'h99, 0);
    wait_idle();
    check_eq("midrst_wr",  wr_cnt - s_wr, 0);
    check_eq("midrst_err", err_cnt - s_err, 2);
    check_eq("midrst_tx",  tx_cnt - s_tx, 0);

    // Random frames against the transaction-level model.
    for (int f = 0; f < 150; f++) begin
      snap();
      kind = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 15));
      e_err = 0; e_wr = 0; e_rd = 0; e_tx = 0;
      if (kind <= 3) begin
        d = 8'($urandom_range(0, 255));
        send_byte(8'hAA, $urandom_range(0, 2));
        send_byte(a, $urandom_range(0, 2));
        send_byte(d, $urandom_range(0, 2));
        e_wr = 1;
        wait_idle();
        check_eq("rnd_wr_addr", 32'(wr_addr), 32'(a));
        check_eq("rnd_wr_dat",  32'(wr_dat), 32'(d));
        ref_mem[a[3:0]] = d;
      end else if (kind <= 6) begin
        TX_BUSY = 1'($urandom_range(0, 1));
        send_byte(8'hBB, $urandom_range(0, 2));
        send_byte(a, $urandom_range(0, 2));
        if (TX_BUSY) begin
          repeat ($urandom_range(0, 8)) @(posedge CLK);
          #1 TX_BUSY = 1'b0;
        end
        e_rd = 1; e_tx = 1;
        wait_idle();
        check_eq("rnd_rd_addr", 32'(rd_addr), 32'(a));
        check_eq("rnd_tx_dat",  32'(tx_dat), 32'(ref_mem[a[3:0]]));
      end else if (kind == 7) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hAA || b == 8'hBB) b = 8'h00;
        send_byte(b, $urandom_range(0, 2));
        e_err = 1;
        wait_idle();
      end else if (kind == 8) begin
        b = 8'(($urandom_range(1, 15) << 4) | $urandom_range(0, 15));
        send_byte($urandom_range(0, 1) ? 8'hAA : 8'hBB, $urandom_range(0, 2));
        send_byte(b, $urandom_range(0, 2));
        e_err = 1;
        wait_idle();
      end else begin
        rf_mute = 1'b1;
        send_byte(8'hBB, $urandom_range(0, 2));
        send_byte(a, $urandom_range(0, 2));
        e_rd = 1; e_err = 1;
        wait_idle();
        rf_mute = 1'b0;
      end
      check_eq("rnd_err_cnt", err_cnt - s_err, e_err);
      check_eq("rnd_wr_cnt",  wr_cnt - s_wr, e_wr);
      check_eq("rnd_rd_cnt",  rd_cnt - s_rd, e_rd);
      check_eq("rnd_tx_cnt",  tx_cnt - s_tx, e_tx);
    end

    check_eq("wr_rd_overlap",   both_cnt, 0);
    check_eq("tx_while_busy",   busy_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_cmd_ctrl.md
REGFILE_CMD_CTRL -- requirements
Module: regfile_cmd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data byte width.
REQ-002 SHALL have parameter ADDR, default 4, register-file address width (depth = 2^ADDR).
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for read data.
REQ-004 CLK  input  1  clock; all logic is rising-edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 RX_P_DATA  input  WIDTH  received command/operand byte.
REQ-007 RX_D_VLD  input  1  single-cycle strobe; RX_P_DATA is valid.
REQ-008 RF_WrEn  output  1  register-file write enable.
REQ-009 RF_RdEn  output  1  register-file read enable.
REQ-010 RF_Address  output  ADDR  register-file address.
REQ-011 RF_WrData  output  WIDTH  register-file write data.
REQ-012 RF_RdData  input  WIDTH  register-file read data.
REQ-013 RF_RdData_VLD  input  1  register-file read-data valid.
REQ-014 TX_P_DATA  output  WIDTH  response byte to transmitter.
REQ-015 TX_D_VLD  output  1  single-cycle response strobe.
REQ-016 TX_BUSY  input  1  transmitter busy; no strobe while high.
REQ-017 CTRL_BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-018 ERR  output  1  single-cycle error pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT and TX_WAIT, and every output SHALL be registered.
REQ-020 In IDLE with RX_D_VLD: byte 0xAA -> WR_ADDR; byte 0xBB -> RD_ADDR; any other byte -> ERR pulse on the next cycle, FSM stays in IDLE.
REQ-021 In WR_ADDR/RD_ADDR with RX_D_VLD, a byte with bits [WIDTH-1:ADDR] nonzero -> ERR pulse, FSM returns to IDLE, no register-file access.
REQ-022 In WR_ADDR with a legal byte: latch byte[ADDR-1:0] into RF_Address -> WR_DATA.
REQ-023 In WR_DATA with RX_D_VLD: RF_WrData = byte and RF_WrEn = 1 for exactly one cycle (the cycle after acceptance) -> IDLE.
REQ-024 In RD_ADDR with a legal byte: latch the address, assert RF_RdEn for exactly one cycle (the cycle after acceptance) -> RD_WAIT; reset the timeout counter to 0.
REQ-025 RF_WrEn and RF_RdEn SHALL never be high in the same cycle.
REQ-026 In RD_WAIT, RF_RdData_VLD SHALL be sampled only in cycles after the RF_RdEn pulse; on the first high sample, capture RF_RdData -> TX_WAIT.
REQ-027 In RD_WAIT, the counter SHALL increment each cycle; on reaching TIMEOUT without valid data -> ERR pulse, IDLE. The counter width is ceil(log2(TIMEOUT+1)) and it saturates, never wraps.
REQ-028 In TX_WAIT: in the first cycle with TX_BUSY low, TX_P_DATA = captured byte and TX_D_VLD = 1 for one cycle -> IDLE. While TX_BUSY is high, hold and wait indefinitely.
REQ-029 RX_D_VLD in RD_WAIT or TX_WAIT: byte discarded, ERR pulse, state unaffected.
REQ-030 When ERR conditions from REQ-027 and REQ-029 coincide, a single one-cycle ERR pulse SHALL be produced.
REQ-031 RF_Address and RF_WrData SHALL hold their last values between accesses; TX_P_DATA SHALL hold its last value after the strobe.
REQ-032 Throughput: a new command byte SHALL be accepted in the first IDLE cycle after returning to IDLE.
REQ-033 Latency: write = 1 cycle from data byte to RF_WrEn; read = RF_RdEn at +1, then TX_D_VLD at (data-valid +1) with TX_BUSY low.

Reset
REQ-034 RST low SHALL immediately force: IDLE, RF_WrEn = 0, RF_RdEn = 0, RF_Address = 0, RF_WrData = 0, TX_P_DATA = 0, TX_D_VLD = 0, CTRL_BUSY = 0, ERR = 0, counter = 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no register-file access or TX strobe after release, and the first byte after release SHALL be decoded as a command.

Verification
REQ-036 After reset, bytes 0xBB, 0x02 with TX_BUSY = 0 -> RF_RdEn pulse, address 2, then TX_D_VLD with TX_P_DATA = 0x81 (register-file reset value).
REQ-037 Bytes 0xAA, 0x05, 0x3C, then 0xBB, 0x05 -> one RF_WrEn pulse with address 5 and data 0x3C; then TX_P_DATA = 0x3C.
REQ-038 Byte 0x7E in IDLE -> one ERR pulse, CTRL_BUSY stays 0; bytes 0xAA, 0x12 -> ERR pulse, no RF_WrEn.
REQ-039 0xBB, 0x03 with TX_BUSY held high for 20 cycles -> no TX_D_VLD until TX_BUSY falls, then a single strobe with 0x20.
REQ-040 RF_RdData_VLD tied low, then 0xBB, 0x01 -> ERR pulse exactly TIMEOUT cycles into RD_WAIT, then IDLE.
REQ-041 RST pulsed low between bytes 0xAA and 0x04, then 0x04, 0x99 sent -> no RF_WrEn; 0x04 produces an ERR pulse.
